hive_level_ctrl: RTL and testbench

HIVE_LEVEL_CTRL -- requirements
Module: hive_level_ctrl

---
 rtl/hive_level_ctrl.sv | 112 +++++++++++
 tb/tb_hive_level_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/hive_level_ctrl.sv
// Level-ring control for the hive core. It provides the stage-0 thread counter
// and the INIT/RUN sweep that clears all stacks after reset. It queues
// per-thread stack clears until each thread reaches stage 0. It also turns
// pop/push errors from the ring pipeline into per-thread sticky bits and one
// interrupt line.
module hive_level_ctrl #(
    parameter int THRDS  = 8,
    parameter int THRD_W = 3
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [THRDS-1:0]  clr_req_i,
    input  logic [THRDS-1:0]  err_ack_i,
    input  logic              pop_er_2_i,
    input  logic              psh_er_6_i,
    output logic [THRD_W-1:0] thrd_0_o,
    output logic              cls_o,
    output logic [THRDS-1:0]  clr_busy_o,
    output logic              init_done_o,
    output logic [THRDS-1:0]  pop_er_o,
    output logic [THRDS-1:0]  psh_er_o,
    output logic              err_irq_o
);

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    localparam logic [THRD_W-1:0] THRD_LAST = THRD_W'(THRDS - 1);

    state_t             state_q, state_d;
    logic [THRD_W-1:0]  thrd_q, thrd_d;
    logic               init_done_q, init_done_d;
    logic [THRDS-1:0]   pend_q, pend_d;
    logic [THRDS-1:0]   pop_q, pop_d;
    logic [THRDS-1:0]   psh_q, psh_d;
    logic [THRDS-1:0]   pop_set, psh_set;
    logic [THRD_W-1:0]  pop_idx, psh_idx;

    // FSM state register: INIT after reset, RUN once the sweep completes
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= ST_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state, clear scheduling and sticky-error update logic
    always_comb begin
        state_d     = state_q;
        thrd_d      = (thrd_q == THRD_LAST) ? '0 : thrd_q + THRD_W'(1);
        cls_o       = (state_q == ST_INIT) | pend_q[thrd_q];
        pend_d      = pend_q;
        pop_set     = '0;
        psh_set     = '0;
        // The error reaching stage N entered the ring at stage 0 N cycles
        // earlier, so it belongs to the thread N steps behind the counter.
        pop_idx     = thrd_q - THRD_W'(2);
        psh_idx     = thrd_q - THRD_W'(6);

        if ((state_q == ST_INIT) && (thrd_q == THRD_LAST)) begin
            state_d = ST_RUN;
        end
        init_done_d = (state_d == ST_RUN);

        // A new request takes priority over the service in progress. The
        // thread then gets a second clear one revolution later.
        if (cls_o) begin
            pend_d[thrd_q] = 1'b0;
        end
        pend_d = pend_d | clr_req_i;

        if (state_q == ST_RUN) begin
            if (pop_er_2_i) begin
                pop_set[pop_idx] = 1'b1;
            end
            if (psh_er_6_i) begin
                psh_set[psh_idx] = 1'b1;
            end
        end
        // A new error takes priority over an acknowledge in the same cycle.
        pop_d = (pop_q & ~err_ack_i) | pop_set;
        psh_d = (psh_q & ~err_ack_i) | psh_set;
    end

    // Datapath registers: thread counter, pending clears, sticky errors
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            thrd_q      <= '0;
            init_done_q <= 1'b0;
            pend_q      <= '0;
            pop_q       <= '0;
            psh_q       <= '0;
        end else begin
            thrd_q      <= thrd_d;
            init_done_q <= init_done_d;
            pend_q      <= pend_d;
            pop_q       <= pop_d;
            psh_q       <= psh_d;
        end
    end

    assign thrd_0_o    = thrd_q;
    assign clr_busy_o  = pend_q;
    assign init_done_o = init_done_q;
    assign pop_er_o    = pop_q;
    assign psh_er_o    = psh_q;
    assign err_irq_o   = |(pop_q | psh_q);

endmodule

// File: tb/tb_hive_level_ctrl.sv
// Testbench for hive_level_ctrl. Directed scenarios and randomized traffic are
// checked against a cycle-count based behavioural model.
module tb_hive_level_ctrl;

    localparam int THRDS  = 8;
    localparam int THRD_W = 3;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic [THRDS-1:0]  clr_req_i;
    logic [THRDS-1:0]  err_ack_i;
    logic              pop_er_2_i;
    logic              psh_er_6_i;
    logic [THRD_W-1:0] thrd_0_o;
    logic              cls_o;
    logic [THRDS-1:0]  clr_busy_o;
    logic              init_done_o;
    logic [THRDS-1:0]  pop_er_o;
    logic [THRDS-1:0]  psh_er_o;
    logic              err_irq_o;

    int n_cmp = 0;
    int n_err = 0;

    // Model: cycles since reset plus per-thread pending and sticky flags
    int         m_cyc;
    bit [7:0]   m_pend;
    bit [7:0]   m_pop;
    bit [7:0]   m_psh;

    hive_level_ctrl #(
        .THRDS  (THRDS),
        .THRD_W (THRD_W)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .clr_req_i   (clr_req_i),
        .err_ack_i   (err_ack_i),
        .pop_er_2_i  (pop_er_2_i),
        .psh_er_6_i  (psh_er_6_i),
        .thrd_0_o    (thrd_0_o),
        .cls_o       (cls_o),
        .clr_busy_o  (clr_busy_o),
        .init_done_o (init_done_o),
        .pop_er_o    (pop_er_o),
        .psh_er_o    (psh_er_o),
        .err_irq_o   (err_irq_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int m_thr();
        return m_cyc % THRDS;
    endfunction

    function automatic bit m_cls();
        return (m_cyc < THRDS) || m_pend[m_thr()];
    endfunction

    // Apply one cycle of inputs, then move the model across the same edge
    task automatic tick(input logic rst_n, input logic [7:0] clr, input logic [7:0] ack,
                        input logic pe, input logic se);
        int thr;
        bit in_init;
        rst_i      = rst_n;
        clr_req_i  = clr;
        err_ack_i  = ack;
        pop_er_2_i = pe;
        psh_er_6_i = se;
        @(posedge clk_i);
        #1;
        if (!rst_n) begin
            m_cyc  = 0;
            m_pend = '0;
            m_pop  = '0;
            m_psh  = '0;
        end else begin
            thr     = m_thr();
            in_init = (m_cyc < THRDS);
            if (m_cls()) m_pend[thr] = 1'b0;
            m_pend = m_pend | clr;
            m_pop  = m_pop & ~ack;
            m_psh  = m_psh & ~ack;
            if (!in_init && pe) m_pop[(thr + THRDS - 2) % THRDS] = 1'b1;
            if (!in_init && se) m_psh[(thr + THRDS - 6) % THRDS] = 1'b1;
            m_cyc++;
        end
        rst_i      = 1'b1;
        clr_req_i  = '0;
        err_ack_i  = '0;
        pop_er_2_i = 1'b0;
        psh_er_6_i = 1'b0;
    endtask

    task automatic idle_to(input int thr);
        for (int i = 0; i < THRDS && m_thr() != thr; i++) tick(1'b1, '0, '0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        tick(1'b0, '0, '0, 1'b0, 1'b0);
        n_cmp++; if (thrd_0_o !== 3'd0) begin n_err++; $display("FAIL reset_thrd: got %0d want 0", thrd_0_o); end
        n_cmp++; if (cls_o !== 1'b1) begin n_err++; $display("FAIL reset_cls: got %b want 1", cls_o); end
        n_cmp++; if (clr_busy_o !== 8'h00) begin n_err++; $display("FAIL reset_busy: got %h want 00", clr_busy_o); end
        n_cmp++; if (init_done_o !== 1'b0) begin n_err++; $display("FAIL reset_init_done: got %b want 0", init_done_o); end
        n_cmp++; if ({pop_er_o, psh_er_o} !== 16'h0000) begin n_err++; $display("FAIL reset_sticky: got %h/%h want 00/00", pop_er_o, psh_er_o); end
        n_cmp++; if (err_irq_o !== 1'b0) begin n_err++; $display("FAIL reset_irq: got %b want 0", err_irq_o); end
    endtask

    task automatic test_init_sweep(input string tag);
        for (int i = 0; i < THRDS; i++) begin
            n_cmp++; if (thrd_0_o !== 3'(i)) begin n_err++; $display("FAIL %s_thrd: got %0d want %0d", tag, thrd_0_o, i); end
            n_cmp++; if (cls_o !== 1'b1) begin n_err++; $display("FAIL %s_cls: i=%0d got %b want 1", tag, i, cls_o); end
            n_cmp++; if (init_done_o !== 1'b0) begin n_err++; $display("FAIL %s_done_early: i=%0d got %b want 0", tag, i, init_done_o); end
            tick(1'b1, '0, '0, 1'b0, 1'b0);
        end
        n_cmp++; if (init_done_o !== 1'b1) begin n_err++; $display("FAIL %s_done: got %b want 1", tag, init_done_o); end
        n_cmp++; if (cls_o !== 1'b0) begin n_err++; $display("FAIL %s_cls_run: got %b want 0", tag, cls_o); end
        n_cmp++; if (thrd_0_o !== 3'd0) begin n_err++; $display("FAIL %s_wrap: got %0d want 0", tag, thrd_0_o); end
    endtask

    task automatic test_clear_basic();
        idle_to(2);
        tick(1'b1, 8'h20, '0, 1'b0, 1'b0);
        n_cmp++; if (clr_busy_o[5] !== 1'b1) begin n_err++; $display("FAIL clr_busy_set: got %b want 1", clr_busy_o[5]); end
        for (int i = 3; i <= 5; i++) begin
            n_cmp++; if (thrd_0_o !== 3'(i)) begin n_err++; $display("FAIL clr_thrd: got %0d want %0d", thrd_0_o, i); end
            n_cmp++; if (cls_o !== (i == 5)) begin n_err++; $display("FAIL clr_cls: thrd=%0d got %b want %b", i, cls_o, (i == 5)); end
            tick(1'b1, '0, '0, 1'b0, 1'b0);
        end
        n_cmp++; if (clr_busy_o[5] !== 1'b0) begin n_err++; $display("FAIL clr_busy_clear: got %b want 0", clr_busy_o[5]); end
        n_cmp++; if (cls_o !== 1'b0) begin n_err++; $display("FAIL clr_cls_after: got %b want 0", cls_o); end
    endtask

    task automatic test_clear_collision();
        tick(1'b1, 8'h08, '0, 1'b0, 1'b0);
        idle_to(3);
        n_cmp++; if (cls_o !== 1'b1) begin n_err++; $display("FAIL coll_cls_first: got %b want 1", cls_o); end
        tick(1'b1, 8'h08, '0, 1'b0, 1'b0);
        n_cmp++; if (clr_busy_o[3] !== 1'b1) begin n_err++; $display("FAIL coll_busy_kept: got %b want 1", clr_busy_o[3]); end
        for (int i = 0; i < THRDS - 1; i++) begin
            n_cmp++; if (cls_o !== 1'b0) begin n_err++; $display("FAIL coll_cls_gap: thrd=%0d got %b want 0", thrd_0_o, cls_o); end
            tick(1'b1, '0, '0, 1'b0, 1'b0);
        end
        n_cmp++; if (thrd_0_o !== 3'd3 || cls_o !== 1'b1) begin n_err++; $display("FAIL coll_cls_second: thrd=%0d cls=%b want thrd=3 cls=1", thrd_0_o, cls_o); end
        tick(1'b1, '0, '0, 1'b0, 1'b0);
        n_cmp++; if (clr_busy_o[3] !== 1'b0) begin n_err++; $display("FAIL coll_busy_done: got %b want 0", clr_busy_o[3]); end
    endtask

    task automatic test_errors();
        idle_to(1);
        tick(1'b1, '0, '0, 1'b1, 1'b1);
        n_cmp++; if (pop_er_o !== 8'h80) begin n_err++; $display("FAIL err_pop: got %h want 80", pop_er_o); end
        n_cmp++; if (psh_er_o !== 8'h08) begin n_err++; $display("FAIL err_psh: got %h want 08", psh_er_o); end
        n_cmp++; if (err_irq_o !== 1'b1) begin n_err++; $display("FAIL err_irq: got %b want 1", err_irq_o); end
    endtask

    task automatic test_err_ack();
        tick(1'b1, '0, 8'h80, 1'b0, 1'b0);
        n_cmp++; if (pop_er_o !== 8'h00) begin n_err++; $display("FAIL ack_clear: got %h want 00", pop_er_o); end
        n_cmp++; if (psh_er_o !== 8'h08) begin n_err++; $display("FAIL ack_other_kept: got %h want 08", psh_er_o); end
        idle_to(1);
        tick(1'b1, '0, '0, 1'b1, 1'b0);
        n_cmp++; if (pop_er_o !== 8'h80) begin n_err++; $display("FAIL ack_reset_up: got %h want 80", pop_er_o); end
        idle_to(1);
        tick(1'b1, '0, 8'h80, 1'b1, 1'b0);
        n_cmp++; if (pop_er_o !== 8'h80) begin n_err++; $display("FAIL ack_set_wins: got %h want 80", pop_er_o); end
        tick(1'b1, '0, 8'hFF, 1'b0, 1'b0);
        n_cmp++; if (err_irq_o !== 1'b0) begin n_err++; $display("FAIL ack_all_irq: got %b want 0", err_irq_o); end
    endtask

    task automatic test_random();
        logic [7:0] clr, ack;
        logic       rn;
        for (int c = 0; c < 400; c++) begin
            n_cmp++; if (thrd_0_o !== 3'(m_thr())) begin n_err++; $display("FAIL rnd_thrd: cyc=%0d got %0d want %0d", c, thrd_0_o, m_thr()); end
            n_cmp++; if (cls_o !== m_cls()) begin n_err++; $display("FAIL rnd_cls: cyc=%0d got %b want %b", c, cls_o, m_cls()); end
            n_cmp++; if (init_done_o !== (m_cyc >= THRDS)) begin n_err++; $display("FAIL rnd_done: cyc=%0d got %b want %b", c, init_done_o, (m_cyc >= THRDS)); end
            n_cmp++; if (clr_busy_o !== m_pend) begin n_err++; $display("FAIL rnd_busy: cyc=%0d got %h want %h", c, clr_busy_o, m_pend); end
            n_cmp++; if (pop_er_o !== m_pop) begin n_err++; $display("FAIL rnd_pop: cyc=%0d got %h want %h", c, pop_er_o, m_pop); end
            n_cmp++; if (psh_er_o !== m_psh) begin n_err++; $display("FAIL rnd_psh: cyc=%0d got %h want %h", c, psh_er_o, m_psh); end
            n_cmp++; if (err_irq_o !== |(m_pop | m_psh)) begin n_err++; $display("FAIL rnd_irq: cyc=%0d got %b want %b", c, err_irq_o, |(m_pop | m_psh)); end
            clr = ($urandom_range(0, 2) == 0) ? (8'($urandom) & 8'($urandom)) : 8'h00;
            ack = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
            rn  = ($urandom_range(0, 99) != 0);
            tick(rn, clr, ack, 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 2) == 0));
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 2 * THRDS && m_cyc < THRDS; i++) tick(1'b1, '0, '0, 1'b0, 1'b0);
        tick(1'b1, 8'hFF, '0, 1'b0, 1'b0);
        tick(1'b1, '0, '0, 1'b1, 1'b1);
        n_cmp++; if (clr_busy_o === 8'h00) begin n_err++; $display("FAIL mid_pre_busy: got %h want nonzero", clr_busy_o); end
        n_cmp++; if (err_irq_o !== 1'b1) begin n_err++; $display("FAIL mid_pre_irq: got %b want 1", err_irq_o); end
        tick(1'b0, '0, '0, 1'b0, 1'b0);
        n_cmp++; if (clr_busy_o !== 8'h00) begin n_err++; $display("FAIL mid_busy: got %h want 00", clr_busy_o); end
        n_cmp++; if ({pop_er_o, psh_er_o} !== 16'h0000) begin n_err++; $display("FAIL mid_sticky: got %h/%h want 00/00", pop_er_o, psh_er_o); end
        n_cmp++; if (err_irq_o !== 1'b0) begin n_err++; $display("FAIL mid_irq: got %b want 0", err_irq_o); end
        test_init_sweep("mid_sweep");
    endtask

    initial begin
        rst_i      = 1'b0;
        clr_req_i  = '0;
        err_ack_i  = '0;
        pop_er_2_i = 1'b0;
        psh_er_6_i = 1'b0;
        m_cyc      = 0;
        m_pend     = '0;
        m_pop      = '0;
        m_psh      = '0;
        test_reset();
        test_init_sweep("init_sweep");
        test_clear_basic();
        test_clear_collision();
        test_errors();
        test_err_ack();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
